// File: rtl/add16_pkg.sv
// add16_pkg: shared definitions for the add16_accum command/response accumulator.
// The package holds the opcode encodings, the FSM state type, flag bit positions,
// the saturation limits, the debug struct and an operand-selection helper.
package add16_pkg;

    // Command opcodes
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Bit positions inside the 5-bit flags vector
    localparam int FLAG_SIGN     = 0;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_PARITY   = 3;
    localparam int FLAG_OVERFLOW = 4;
    localparam int FLAG_W        = 5;

    // Saturation limits for the saturating ADD build
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    // Observability bundle: controller state plus the latched command
    typedef struct packed {
        state_t      state;
        op_t         op;
        logic [15:0] data;
    } dbg_t;

    // Adder operands for a command, returned as {x, y}.
    // LOAD 0/data, ADD acc/data, CLEAR 0/0, READ acc/0.
    function automatic logic [31:0] pick_operands(input op_t op,
                                                  input logic [15:0] acc,
                                                  input logic [15:0] data);
        logic [31:0] xy;
        xy = 32'h0;
        case (op)
            OP_LOAD:  xy = {16'h0000, data};
            OP_ADD:   xy = {acc, data};
            OP_CLEAR: xy = 32'h0;
            OP_READ:  xy = {acc, 16'h0000};
            default:  xy = 32'h0;
        endcase
        return xy;
    endfunction

endpackage

// File: rtl/add16_accum_if.sv
// add16_accum_if: command and response channels of the accumulator.
//
// Handshake rules: a command transfers on a rising edge where in_valid and
// in_ready are both 1; a response transfers on a rising edge where out_valid
// and out_ready are both 1. in_valid seen while in_ready is 0 is dropped,
// not queued. acc/flags are meaningful while out_valid is 1 and hold steady
// until the response is consumed.
interface add16_accum_if;
    import add16_pkg::*;

    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] acc;
    logic [4:0]  flags;

    // Command source / response sink side
    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, acc, flags
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, acc, flags
    );

endinterface

// File: rtl/adder16bit.sv
// adder16bit: combinational 16-bit adder with status flags.
// Lives beside add16_accum at the parent level; the accumulator only sees
// its operands and results through ports.
// parity is the XOR of all sum bits (1 = odd number of ones).
// overflow is two's-complement signed overflow.
module adder16bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] z,
    output logic        sign,
    output logic        zero,
    output logic        carry,
    output logic        parity,
    output logic        overflow
);

    logic [16:0] sum;

    // Sum and flags derived from the 17-bit widened addition
    always_comb begin
        sum      = {1'b0, x} + {1'b0, y};
        z        = sum[15:0];
        carry    = sum[16];
        sign     = sum[15];
        zero     = (sum[15:0] == 16'h0000);
        parity   = ^sum[15:0];
        overflow = (x[15] == y[15]) && (sum[15] != x[15]);
    end

endmodule

// File: rtl/add16_accum.sv
// add16_accum: 16-bit accumulator driving an external adder16bit.
// A command is accepted in IDLE, the registered operands are presented to
// the adder for one EXEC cycle, the sum and flags are captured at the end
// of EXEC, and the response is held in RESP until consumed.
// Optional feature: define ADD16_SAT_EN for saturating ADD; by default ADD
// wraps modulo 2^16.
module add16_accum
    import add16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    add16_accum_if.slave       bus,
    output logic [15:0]        add_x,
    output logic [15:0]        add_y,
    input  logic [15:0]        add_z,
    input  logic               add_sign,
    input  logic               add_zero,
    input  logic               add_carry,
    input  logic               add_parity,
    input  logic               add_overflow,
    output dbg_t               dbg
);

    state_t              state;
    state_t              state_nxt;
    op_t                 op_r;
    logic [15:0]         data_r;
    logic [15:0]         acc_r;
    logic [FLAG_W-1:0]   flags_r;
    logic [FLAG_W-1:0]   add_flags;
    logic [15:0]         acc_nxt;
    logic [31:0]         operands;
    logic                ready;
    logic                valid;
    logic                accept;
    logic                commit;

    assign add_flags = {add_overflow, add_parity, add_carry, add_zero, add_sign};
    assign operands  = pick_operands(bus.in_op, acc_r, bus.in_data);

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.acc       = acc_r;
    assign bus.flags     = flags_r;

    assign dbg = '{state: state, op: op_r, data: data_r};

    // Controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                commit    = (op_r != OP_READ);
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Value written into acc at the end of EXEC
    always_comb begin
        acc_nxt = add_z;
`ifdef ADD16_SAT_EN
        if (op_r == OP_ADD && add_overflow) begin
            acc_nxt = acc_r[15] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Command latch, adder operand registers and accumulator/flags update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r    <= OP_LOAD;
            data_r  <= 16'h0000;
            add_x   <= 16'h0000;
            add_y   <= 16'h0000;
            acc_r   <= 16'h0000;
            flags_r <= '0;
        end else begin
            if (accept) begin
                op_r   <= bus.in_op;
                data_r <= bus.in_data;
                add_x  <= operands[31:16];
                add_y  <= operands[15:0];
            end
            if (commit) begin
                acc_r   <= acc_nxt;
                flags_r <= add_flags;
            end
        end
    end

endmodule

// File: tb/tb_add16_accum.sv
// tb_add16_accum: directed bench for add16_accum wired to adder16bit.
// Build with +define+ADD16_SAT_EN to exercise the saturating ADD variant.
module tb_add16_accum;
    import add16_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] add_x;
    logic [15:0] add_y;
    logic [15:0] add_z;
    logic        add_sign;
    logic        add_zero;
    logic        add_carry;
    logic        add_parity;
    logic        add_overflow;
    dbg_t        dbg;

    int          n_vec;
    int          n_err;
    logic [15:0] cur_acc;

    add16_accum_if bus ();

    add16_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .add_x        (add_x),
        .add_y        (add_y),
        .add_z        (add_z),
        .add_sign     (add_sign),
        .add_zero     (add_zero),
        .add_carry    (add_carry),
        .add_parity   (add_parity),
        .add_overflow (add_overflow),
        .dbg          (dbg)
    );

    adder16bit u_adder (
        .x        (add_x),
        .y        (add_y),
        .z        (add_z),
        .sign     (add_sign),
        .zero     (add_zero),
        .carry    (add_carry),
        .parity   (add_parity),
        .overflow (add_overflow)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command from IDLE (called on a falling edge), follow it through
    // EXEC and RESP, hold RESP for 'hold' extra cycles, then consume it.
    task automatic do_cmd(input string tag, input op_t op, input logic [15:0] data,
                          input logic [15:0] exp_acc, input logic [4:0] exp_flags,
                          input int hold);
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        case (op)
            OP_LOAD:  begin exp_x = 16'h0000;  exp_y = data;     end
            OP_ADD:   begin exp_x = cur_acc;   exp_y = data;     end
            OP_CLEAR: begin exp_x = 16'h0000;  exp_y = 16'h0000; end
            default:  begin exp_x = cur_acc;   exp_y = 16'h0000; end
        endcase
        check_val({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        @(negedge clk);
        // EXEC: keep a conflicting command asserted; it must be dropped
        bus.in_op   = OP_CLEAR;
        bus.in_data = ~data;
        check_val({tag, ".exec_state"}, 32'(dbg.state), 32'(ST_EXEC));
        check_val({tag, ".exec_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_val({tag, ".exec_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, ".add_x"}, 32'(add_x), 32'(exp_x));
        check_val({tag, ".add_y"}, 32'(add_y), 32'(exp_y));
        @(negedge clk);
        check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, ".acc"}, 32'(bus.acc), 32'(exp_acc));
        check_val({tag, ".flags"}, 32'(bus.flags), 32'(exp_flags));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val({tag, ".hold_out_valid"}, 32'(bus.out_valid), 32'd1);
            check_val({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check_val({tag, ".hold_acc"}, 32'(bus.acc), 32'(exp_acc));
            check_val({tag, ".hold_flags"}, 32'(bus.flags), 32'(exp_flags));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val({tag, ".back_idle"}, 32'(dbg.state), 32'(ST_IDLE));
        check_val({tag, ".done_out_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_val({tag, ".not_queued"}, 32'(dbg.state), 32'(ST_IDLE));
        cur_acc = exp_acc;
    endtask

    logic [15:0] sat_exp;

    // Directed sequence
    initial begin
        n_vec         = 0;
        n_err         = 0;
        cur_acc       = 16'h0000;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = OP_LOAD;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
`ifdef ADD16_SAT_EN
        sat_exp = 16'h8000;
`else
        sat_exp = 16'h0FFF;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst.state", 32'(dbg.state), 32'(ST_IDLE));
        check_val("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst.acc", 32'(bus.acc), 32'h0);
        check_val("rst.flags", 32'(bus.flags), 32'h0);
        check_val("rst.add_xy", {add_x, add_y}, 32'h0);
        check_val("rst.op_data", {14'h0, dbg.op, dbg.data}, 32'h0);

        // Signed overflow with carry: wraps, or saturates negative
        do_cmd("load_8fff", OP_LOAD, 16'h8FFF, 16'h8FFF, 5'b01001, 0);
        do_cmd("add_8000",  OP_ADD,  16'h8000, sat_exp,  5'b10100, 0);

        // Wrap to zero with carry, no signed overflow
        do_cmd("load_fffe", OP_LOAD, 16'hFFFE, 16'hFFFE, 5'b01001, 0);
        do_cmd("add_0002",  OP_ADD,  16'h0002, 16'h0000, 5'b00110, 0);

        // All ones result, then READ leaves it untouched
        do_cmd("load_aaaa", OP_LOAD, 16'hAAAA, 16'hAAAA, 5'b00001, 0);
        do_cmd("add_5555",  OP_ADD,  16'h5555, 16'hFFFF, 5'b00001, 0);
        do_cmd("read",      OP_READ, 16'h1357, 16'hFFFF, 5'b00001, 0);

        // Response back-pressure for 3 cycles with a competing command
        do_cmd("read_hold", OP_READ, 16'h0000, 16'hFFFF, 5'b00001, 3);

        // Reset during EXEC aborts the in-flight LOAD
        bus.in_valid = 1'b1;
        bus.in_op    = OP_LOAD;
        bus.in_data  = 16'h1234;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("abort.exec_state", 32'(dbg.state), 32'(ST_EXEC));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("abort.state", 32'(dbg.state), 32'(ST_IDLE));
        check_val("abort.acc", 32'(bus.acc), 32'h0);
        check_val("abort.flags", 32'(bus.flags), 32'h0);
        check_val("abort.add_xy", {add_x, add_y}, 32'h0);
        check_val("abort.out_valid", 32'(bus.out_valid), 32'd0);
        cur_acc = 16'h0000;
        @(negedge clk);

        // LOAD then CLEAR
        do_cmd("load_0001", OP_LOAD,  16'h0001, 16'h0001, 5'b01000, 0);
        do_cmd("clear",     OP_CLEAR, 16'hBEEF, 16'h0000, 5'b00010, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add16_accum.md
ADD16_ACCUM -- requirements
Module: add16_accum

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  command present.
REQ-004 in_ready  output  1  command can be accepted.
REQ-005 in_op  input  2  00 LOAD, 01 ADD, 10 CLEAR, 11 READ.
REQ-006 in_data  input  16  operand for LOAD/ADD.
REQ-007 add_x, add_y  output  16 each  operands driven to external adder16bit.
REQ-008 add_z  input  16  adder sum.
REQ-009 add_sign, add_zero, add_carry, add_parity, add_overflow  input  1 each  adder flags.
REQ-010 acc  output  16  accumulator value.
REQ-011 flags  output  5  {overflow, parity, carry, zero, sign}, bit 0 = sign.
REQ-012 out_valid  output  1  response present.
REQ-013 out_ready  input  1  response consumed.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP.
- IDLE: in_ready=1; on in_valid, latch in_op/in_data into op_r/data_r, go to EXEC.
- EXEC: in_ready=0; sample adder results at end of cycle; go to RESP.
- RESP: out_valid=1; go to IDLE when out_ready=1, else hold.
REQ-015 add_x/add_y SHALL be registered and stable for the whole EXEC cycle: LOAD 0/data_r; ADD acc/data_r; CLEAR 0/0; READ acc/0.
REQ-016 At end of EXEC, LOAD/ADD/CLEAR SHALL write acc<=add_z and flags<=adder flags; READ SHALL leave acc and flags unchanged.
REQ-017 Latency SHALL be: command accepted in cycle N, acc/flags updated at edge ending N+1, out_valid high from N+2.
REQ-018 Maximum throughput SHALL be one command per 3 cycles; in_valid while in_ready=0 SHALL be ignored (not queued).
REQ-019 acc and flags SHALL stay constant while out_valid=1, independent of in_valid or in_data.
REQ-020 Arithmetic SHALL be 16-bit modulo (wrap) unless REQ-026 applies; carry-out is reported only via flags[2].

Reset
REQ-021 With rst_n=0 at a clock edge: state=IDLE, acc=0x0000, flags=5'b0, add_x=add_y=0, op_r=data_r=0.
REQ-022 Outputs SHALL read in_ready=1 and out_valid=0 the cycle after reset deasserts.
REQ-023 Reset in EXEC or RESP SHALL abort the operation; acc SHALL NOT take the in-flight result.
REQ-024 Reset SHALL take priority over every other event on the same edge.

Configuration
REQ-025 The macro ADD16_SAT_EN SHALL select saturating ADD.
REQ-026 With ADD16_SAT_EN defined: ADD with add_overflow=1 SHALL write acc=0x7FFF if acc[15]=0, else 0x8000; flags SHALL still be the raw adder flags. LOAD, CLEAR and READ are unaffected.
REQ-027 Without ADD16_SAT_EN: acc<=add_z always (wrap).

Structure
REQ-028 Package add16_pkg SHALL hold: op encodings, FSM state typedef, flag bit indices, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000.
REQ-029 add16_accum SHALL contain no sub-module; adder16bit is instantiated beside it at the parent level, wired add_x->x, add_y->y, z->add_z, flags->add_*.

Verification (bench instantiates add16_accum and adder16bit together)
REQ-030 LOAD 0x8FFF, then ADD 0x8000:
- Wrap build: acc=0x0FFF, carry=1, overflow=1, sign=0.
- ADD16_SAT_EN build: acc=0x8000, same flags.
REQ-031 LOAD 0xFFFE, then ADD 0x0002 -> acc=0x0000, zero=1, carry=1, overflow=0.
REQ-032 LOAD 0xAAAA, then ADD 0x5555 -> acc=0xFFFF, sign=1, carry=0, overflow=0; then READ -> same acc and flags, out_valid 2 cycles after accept.
REQ-033 out_ready held low for 3 cycles in RESP -> out_valid, acc and flags stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-034 LOAD 0x1234 accepted, rst_n=0 during EXEC -> acc=0x0000, flags=0, state IDLE; CLEAR after LOAD 0x0001 -> acc=0, zero=1.
